// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential integer divider: default sizing,
// FSM state encoding and the signed-minimum operand pattern.
package alu_div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    localparam logic [DIV_WIDTH-1:0] DIV_SMIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference only when it did not borrow.
module div_step import alu_div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so bit WIDTH of trial is a clean borrow flag.
    always_comb begin
        shifted  = {rem, dividend_msb};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
// on operand magnitudes, with sign fix-up and single-cycle special cases.
module div32_seq import alu_div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[WIDTH-1]),
        .divisor      (dvs_q),
        .next_rem     (step_rem),
        .q_bit        (step_qbit)
    );

    always_comb begin
        abs_a = (is_signed && A[WIDTH-1]) ? -A : A;
        abs_b = (is_signed && B[WIDTH-1]) ? -B : B;
    end

    // The dividend register doubles as the quotient: bits shift out of the top
    // into the remainder while quotient bits enter at the bottom.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    dvd_d     = abs_a;
                    dvs_d     = abs_b;
                    rem_d     = '0;
                    cnt_d     = CNT_LAST;
                    neg_quo_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_rem_d = is_signed & A[WIDTH-1];
                    dz_d      = 1'b0;
                    if (B == '0) begin
                        quo_d   = '1;
                        rmd_d   = A;
                        dz_d    = 1'b1;
                        state_d = DIV_DONE;
                    end else if (is_signed && (A == SMIN) && (B == '1)) begin
                        quo_d   = A;
                        rmd_d   = '0;
                        state_d = DIV_DONE;
                    end else begin
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_FIX: begin
                quo_d   = neg_quo_q ? -dvd_q : dvd_q;
                rmd_d   = neg_rem_q ? -rem_q : rem_q;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign busy        = (state_q != DIV_IDLE);
    assign done        = (state_q == DIV_DONE);
    assign Q           = quo_q;
    assign R           = rmd_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: expected results are queued at issue time
// and popped when the done pulse is observed.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        div_by_zero;

    div32_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [5:0]  lat;
    } vec_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;

    vec_t arith_tbl [0:7] = '{
        '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 6'd34},
        '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 6'd34},
        '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0, 6'd34},
        '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, 6'd34},
        '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 6'd34},
        '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0, 6'd34},
        '{32'h80000000,   32'd2,          1'b1, 32'hC0000000,   32'd0,          1'b0, 6'd34},
        '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0, 6'd34}
    };

    vec_t short_tbl [0:3] = '{
        '{32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1, 6'd1},
        '{32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678,   1'b1, 6'd1},
        '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 6'd1},
        '{32'hFFFFFFFF,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 6'd1}
    };

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        e = mk(32'd0, 32'd0, 1'b0, 34);
        if (b == 32'd0) begin
            e = mk(32'hFFFFFFFF, a, 1'b1, 1);
        end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e = mk(a, 32'd0, 1'b0, 1);
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
        @(negedge clk);
        A = a; B = b; is_signed = s; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom; B = $urandom; is_signed = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int bc, output bit to);
        cyc = 0; bc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end while (!done && cyc < 200);
        to = !done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        #2;
        tests_run++;
        if ({busy, done, Q, R, div_by_zero} !== 67'd0) begin
            fails++;
            $display("FAIL reset_state got busy=%b done=%b Q=%h R=%h dz=%b want all zero", busy, done, Q, R, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith;
        int cyc, bc; bit to; exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(arith_tbl[i].a, arith_tbl[i].b, arith_tbl[i].s,
                  mk(arith_tbl[i].q, arith_tbl[i].r, arith_tbl[i].dz, int'(arith_tbl[i].lat)));
            wait_done(cyc, bc, to);
            e = sb.pop_front();
            tests_run++;
            if (to || cyc != e.lat || bc != e.lat) begin
                fails++;
                $display("FAIL arith[%0d] latency got %0d busy %0d timeout=%0b want %0d", i, cyc, bc, to, e.lat);
            end
            tests_run++;
            if ({Q, R, div_by_zero} !== {e.q, e.r, e.dz}) begin
                fails++;
                $display("FAIL arith[%0d] result got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b", i, Q, R, div_by_zero, e.q, e.r, e.dz);
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL arith[%0d] after_done got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_shortcuts;
        int cyc, bc; bit to; exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(short_tbl[i].a, short_tbl[i].b, short_tbl[i].s,
                  mk(short_tbl[i].q, short_tbl[i].r, short_tbl[i].dz, int'(short_tbl[i].lat)));
            wait_done(cyc, bc, to);
            e = sb.pop_front();
            tests_run++;
            if (to || cyc != e.lat || bc != e.lat) begin
                fails++;
                $display("FAIL short[%0d] latency got %0d busy %0d timeout=%0b want %0d", i, cyc, bc, to, e.lat);
            end
            tests_run++;
            if ({Q, R, div_by_zero} !== {e.q, e.r, e.dz}) begin
                fails++;
                $display("FAIL short[%0d] result got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b", i, Q, R, div_by_zero, e.q, e.r, e.dz);
            end
            repeat (3) @(negedge clk);
            tests_run++;
            if ({busy, Q, R, div_by_zero} !== {1'b0, e.q, e.r, e.dz}) begin
                fails++;
                $display("FAIL short[%0d] hold got busy=%b Q=%h R=%h dz=%b want busy=0 Q=%h R=%h dz=%b", i, busy, Q, R, div_by_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_random;
        int cyc, bc; bit to; exp_t e;
        logic [31:0] a, b; logic s;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 4) b = 32'd0;
            s = 1'($urandom);
            issue(a, b, s, model(a, b, s));
            wait_done(cyc, bc, to);
            e = sb.pop_front();
            tests_run++;
            if (to || cyc != e.lat) begin
                fails++;
                $display("FAIL rand[%0d] latency got %0d timeout=%0b want %0d", i, cyc, to, e.lat);
            end
            tests_run++;
            if ({Q, R, div_by_zero} !== {e.q, e.r, e.dz}) begin
                fails++;
                $display("FAIL rand[%0d] result a=%h b=%h s=%b got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b", i, a, b, s, Q, R, div_by_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc; bit to; exp_t e;
        @(negedge clk);
        A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
        sb.push_back(mk(32'd14, 32'd2, 1'b0, 34));
        cyc = 0; bc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bc++;
            if (!done) begin
                A = $urandom; B = $urandom; is_signed = 1'($urandom);
            end
        end while (!done && cyc < 200);
        e = sb.pop_front();
        tests_run++;
        if (!done || cyc != e.lat || bc != e.lat) begin
            fails++;
            $display("FAIL b2b_first latency got %0d busy %0d want %0d", cyc, bc, e.lat);
        end
        tests_run++;
        if ({Q, R, div_by_zero} !== {e.q, e.r, e.dz}) begin
            fails++;
            $display("FAIL b2b_first result got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b", Q, R, div_by_zero, e.q, e.r, e.dz);
        end
        A = 32'hFFFFFFFF; B = 32'd1; is_signed = 1'b0;
        sb.push_back(mk(32'hFFFFFFFF, 32'd0, 1'b0, 34));
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept got busy=%b want 1", busy);
        end
        start = 1'b0;
        wait_done(cyc, bc, to);
        e = sb.pop_front();
        tests_run++;
        if (to || cyc + 1 != e.lat) begin
            fails++;
            $display("FAIL b2b_second latency got %0d timeout=%0b want %0d", cyc + 1, to, e.lat);
        end
        tests_run++;
        if ({Q, R, div_by_zero} !== {e.q, e.r, e.dz}) begin
            fails++;
            $display("FAIL b2b_second result got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b", Q, R, div_by_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_reset_midop;
        int cyc, bc, seen; bit to; exp_t e;
        issue(32'd1000, 32'd7, 1'b0, mk(32'd142, 32'd6, 1'b0, 34));
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, Q, R, div_by_zero} !== 67'd0) begin
            fails++;
            $display("FAIL midop_reset got busy=%b done=%b Q=%h R=%h dz=%b want all zero", busy, done, Q, R, div_by_zero);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midop_no_done got %0d active cycles want 0", seen);
        end
        issue(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0, 1'b0, 34));
        wait_done(cyc, bc, to);
        e = sb.pop_front();
        tests_run++;
        if (to || cyc != e.lat) begin
            fails++;
            $display("FAIL post_reset latency got %0d timeout=%0b want %0d", cyc, to, e.lat);
        end
        tests_run++;
        if ({Q, R, div_by_zero} !== {e.q, e.r, e.dz}) begin
            fails++;
            $display("FAIL post_reset result got Q=%h R=%h dz=%b want Q=%h R=%h dz=%b", Q, R, div_by_zero, e.q, e.r, e.dz);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shortcuts();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
